alu_decode_stage: RTL and testbench
===================================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands and register data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Instruction  input  32  instruction word from IF/ID.
REQ-005 InValid  input  1  Instruction/ReadData are a real instruction this cycle.
REQ-006 Stall  input  1  hold all registered outputs unchanged.
REQ-007 Flush  input  1  load a bubble instead of the current instruction.
REQ-008 ReadData1, ReadData2  input  WIDTH each  register-file values for rs, rt.
REQ-009 ALUcontrol  output  4  registered ALU operation code for the EX stage.
REQ-010 OperandA, OperandB  output  WIDTH each  registered ALU operands.
REQ-011 StoreData  output  WIDTH  registered rt value for sw.
REQ-012 WriteReg  output  5  registered destination register number.
REQ-013 RegWrite, MemRead, MemWrite, Branch, BranchNe, Jump  output  1 each  registered control flags.
REQ-014 ExValid  output  1  EX-stage registers hold a real instruction.
REQ-015 Illegal  output  1  registered one-cycle flag: unsupported opcode/funct decoded.

Function
REQ-016 ALUcontrol encoding SHALL be: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 1111 no-op (ALU outputs 0).
REQ-017 Decode (opcode=Instruction[31:26], funct=[5:0]) SHALL map: R-type 000000 with funct 100000/100010/100100/100101/101010 -> add/sub/and/or/slt, RegWrite=1, WriteReg=rd[15:11], OperandB=ReadData2.
REQ-018 addi 001000 -> add, OperandB=sign-extended imm[15:0], RegWrite=1, WriteReg=rt[20:16].
REQ-019 andi 001100 -> and, OperandB=zero-extended imm[15:0], RegWrite=1, WriteReg=rt.
REQ-020 lw 100011 -> add, sign-extended imm, MemRead=1, RegWrite=1, WriteReg=rt; sw 101011 -> add, sign-extended imm, MemWrite=1, StoreData=ReadData2.
REQ-021 beq 000100 -> sub, OperandB=ReadData2, Branch=1; bne 000101 -> sub, Branch=1, BranchNe=1.
REQ-022 j 000010 -> ALUcontrol=1111, Jump=1, operands 0.
REQ-023 OperandA SHALL equal ReadData1 for every non-jump instruction.
REQ-024 Latency: decoded fields SHALL appear on outputs exactly one clk edge after capture.
REQ-025 Bubble state: ExValid=0, all control flags 0, ALUcontrol=1111, OperandA/B, StoreData=0, WriteReg=0.
REQ-026 Edge priority: Flush > Stall > load; Flush during Stall SHALL load a bubble.
REQ-027 Stall=1 (no Flush) SHALL hold every output, including Illegal, unchanged.
REQ-028 InValid=0 (no Stall) SHALL load a bubble.
REQ-029 Unsupported opcode or R-type funct with InValid=1 SHALL load a bubble and set Illegal=1 for that cycle; Illegal=0 on every other load.
REQ-030 Sign extension SHALL replicate imm[15] up to WIDTH; no other width conversion permitted.

Reset
REQ-031 reset=1 SHALL immediately (asynchronously) force the bubble state and Illegal=0, regardless of clk, Stall, Flush.
REQ-032 Reset asserted mid-stall SHALL discard the held instruction; first capture after deassertion is the next edge with Stall=0.

Structure
REQ-033 Opcode, funct and ALUcontrol code constants SHALL live in the shared package, also used by ALU and control units.
REQ-034 Combinational decode SHALL be one sub-module, alu_op_decoder (Instruction in, unregistered control/ALUcontrol/imm-select out); alu_decode_stage holds the pipeline register.

Verification
REQ-035 add $3,$1,$2 (0x00221820), R1=5, R2=7, InValid=1 -> next edge: ALUcontrol=0000, OperandA=5, OperandB=7, WriteReg=3, RegWrite=1, ExValid=1.
REQ-036 addi $2,$1,-4 (0x2022FFFC), R1=10 -> OperandB=0xFFFFFFFC, ALUcontrol=0000, WriteReg=2; andi imm 0x8001 -> OperandB=0x00008001, ALUcontrol=0010.
REQ-037 sw $5,8($4) (0xAC850008), R1=0x100, R2=0xAB -> OperandB=8, StoreData=0xAB, MemWrite=1, RegWrite=0; bne -> ALUcontrol=0001, Branch=1, BranchNe=1.
REQ-038 Load lw, then Stall=1 for 3 edges with changing Instruction -> outputs stay lw; Stall=1 and Flush=1 together -> bubble (ExValid=0, ALUcontrol=1111).
REQ-039 Opcode 111111 with InValid=1 -> bubble, Illegal=1 one cycle, Illegal=0 after next valid add.
REQ-040 reset asserted between clk edges while ExValid=1 -> outputs go to bubble before next edge; hold reset 2 edges, release, first add captured on following edge.

Source files
------------

// File: rtl/alu_decode_pkg.sv
// Shared opcode/funct/ALU-code constants and decode-select types used by the
// decode stage, ALU and control units.
package alu_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SLT = 4'b0100,
    ALU_NOP = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    BSEL_ZERO = 2'd0,
    BSEL_RT   = 2'd1,
    BSEL_IMM  = 2'd2
  } bsel_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic branch_ne;
    logic jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/alu_decode_stage_dec.sv
// alu_op_decoder: purely combinational instruction decode, no state.
// Produces ALU op, control flags, operand selects, extended immediate and dest reg.
module alu_op_decoder
  import alu_decode_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      i_instr,
  output alu_op_t          o_alu_op,
  output ctrl_t            o_ctrl,
  output bsel_t            o_bsel,
  output logic             o_use_rs,
  output logic [WIDTH-1:0] o_imm,
  output logic [4:0]       o_write_reg,
  output logic             o_illegal
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic       w_zext;
  logic       w_unused_rs;

  assign w_opcode    = i_instr[31:26];
  assign w_funct     = i_instr[5:0];
  // rs number is consumed by the register file, not here
  assign w_unused_rs = ^i_instr[25:21];

  assign o_imm = w_zext ? {{(WIDTH-16){1'b0}}, i_instr[15:0]}
                        : {{(WIDTH-16){i_instr[15]}}, i_instr[15:0]};

  always_comb begin
    o_alu_op    = ALU_NOP;
    o_ctrl      = CTRL_NONE;
    o_bsel      = BSEL_ZERO;
    o_use_rs    = 1'b1;
    o_write_reg = 5'd0;
    o_illegal   = 1'b0;
    w_zext      = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        o_bsel           = BSEL_RT;
        o_ctrl.reg_write = 1'b1;
        o_write_reg      = i_instr[15:11];
        case (w_funct)
          FN_ADD:  o_alu_op = ALU_ADD;
          FN_SUB:  o_alu_op = ALU_SUB;
          FN_AND:  o_alu_op = ALU_AND;
          FN_OR:   o_alu_op = ALU_OR;
          FN_SLT:  o_alu_op = ALU_SLT;
          default: o_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_LW: begin
        o_alu_op         = (w_opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
        w_zext           = (w_opcode == OP_ANDI);
        o_bsel           = BSEL_IMM;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.mem_read  = (w_opcode == OP_LW);
        o_write_reg      = i_instr[20:16];
      end
      OP_SW: begin
        o_alu_op         = ALU_ADD;
        o_bsel           = BSEL_IMM;
        o_ctrl.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        o_alu_op         = ALU_SUB;
        o_bsel           = BSEL_RT;
        o_ctrl.branch    = 1'b1;
        o_ctrl.branch_ne = (w_opcode == OP_BNE);
      end
      OP_J: begin
        o_ctrl.jump = 1'b1;
        o_use_rs    = 1'b0;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// ID/EX pipeline register: captures decoded instruction, one clk edge latency.
// Stall holds every output; Flush or InValid=0 loads a bubble; illegal ops load a bubble + Illegal.
module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instruction,
  input  logic             InValid,
  input  logic             Stall,
  input  logic             Flush,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  output logic [3:0]       ALUcontrol,
  output logic [WIDTH-1:0] OperandA,
  output logic [WIDTH-1:0] OperandB,
  output logic [WIDTH-1:0] StoreData,
  output logic [4:0]       WriteReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             BranchNe,
  output logic             Jump,
  output logic             ExValid,
  output logic             Illegal
);

  alu_op_t          w_alu_op;
  ctrl_t            w_ctrl;
  bsel_t            w_bsel;
  logic             w_use_rs;
  logic [WIDTH-1:0] w_imm;
  logic [4:0]       w_write_reg;
  logic             w_illegal;
  logic [WIDTH-1:0] w_operand_b;
  logic             w_update;
  logic             w_load;
  logic             w_set_ill;

  alu_op_t          r_alu_op;
  ctrl_t            r_ctrl;
  logic [WIDTH-1:0] r_operand_a;
  logic [WIDTH-1:0] r_operand_b;
  logic [WIDTH-1:0] r_store_data;
  logic [4:0]       r_write_reg;
  logic             r_valid;
  logic             r_illegal;

  alu_op_decoder #(.WIDTH(WIDTH)) u_dec (
    .i_instr     (Instruction),
    .o_alu_op    (w_alu_op),
    .o_ctrl      (w_ctrl),
    .o_bsel      (w_bsel),
    .o_use_rs    (w_use_rs),
    .o_imm       (w_imm),
    .o_write_reg (w_write_reg),
    .o_illegal   (w_illegal)
  );

  always_comb begin
    w_operand_b = '0;
    case (w_bsel)
      BSEL_RT:  w_operand_b = ReadData2;
      BSEL_IMM: w_operand_b = w_imm;
      default:  w_operand_b = '0;
    endcase
  end

  // Flush overrides Stall; anything that is not a clean load becomes a bubble.
  assign w_update  = Flush || !Stall;
  assign w_load    = !Flush && InValid && !w_illegal;
  assign w_set_ill = !Flush && InValid && w_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_op     <= ALU_NOP;
      r_ctrl       <= CTRL_NONE;
      r_operand_a  <= '0;
      r_operand_b  <= '0;
      r_store_data <= '0;
      r_write_reg  <= 5'd0;
      r_valid      <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (w_update) begin
      r_alu_op     <= w_load ? w_alu_op : ALU_NOP;
      r_ctrl       <= w_load ? w_ctrl : CTRL_NONE;
      r_operand_a  <= (w_load && w_use_rs) ? ReadData1 : '0;
      r_operand_b  <= w_load ? w_operand_b : '0;
      r_store_data <= (w_load && w_ctrl.mem_write) ? ReadData2 : '0;
      r_write_reg  <= w_load ? w_write_reg : 5'd0;
      r_valid      <= w_load;
      r_illegal    <= w_set_ill;
    end
  end

  assign ALUcontrol = r_alu_op;
  assign OperandA   = r_operand_a;
  assign OperandB   = r_operand_b;
  assign StoreData  = r_store_data;
  assign WriteReg   = r_write_reg;
  assign RegWrite   = r_ctrl.reg_write;
  assign MemRead    = r_ctrl.mem_read;
  assign MemWrite   = r_ctrl.mem_write;
  assign Branch     = r_ctrl.branch;
  assign BranchNe   = r_ctrl.branch_ne;
  assign Jump       = r_ctrl.jump;
  assign ExValid    = r_valid;
  assign Illegal    = r_illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed + randomized bench for alu_decode_stage against an instruction-level model.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instruction;
  logic        InValid, Stall, Flush;
  logic [31:0] ReadData1, ReadData2;
  logic [3:0]  ALUcontrol;
  logic [31:0] OperandA, OperandB, StoreData;
  logic [4:0]  WriteReg;
  logic        RegWrite, MemRead, MemWrite, Branch, BranchNe, Jump, ExValid, Illegal;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] a, b, st;
    logic [4:0]  wr;
    logic        rw, mr, mw, br, bne, j, v, ill;
  } exp_t;

  exp_t m;

  always #5 clk = ~clk;

  alu_decode_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Instruction(Instruction), .InValid(InValid),
    .Stall(Stall), .Flush(Flush), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ALUcontrol(ALUcontrol), .OperandA(OperandA), .OperandB(OperandB),
    .StoreData(StoreData), .WriteReg(WriteReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .BranchNe(BranchNe),
    .Jump(Jump), .ExValid(ExValid), .Illegal(Illegal)
  );

  function automatic exp_t bubble();
    exp_t e;
    e.alu = 4'hF; e.a = 0; e.b = 0; e.st = 0; e.wr = 0;
    e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.bne = 0; e.j = 0; e.v = 0; e.ill = 0;
    return e;
  endfunction

  // Instruction semantics straight from the ISA table: what EX should see.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rd1, input logic [31:0] rd2);
    exp_t e;
    int   simm;
    int   opc;
    int   fn;
    logic ok;
    e    = bubble();
    simm = $signed(ins[15:0]);
    opc  = int'(ins[31:26]);
    fn   = int'(ins[5:0]);
    ok   = 1'b1;
    e.a  = rd1;
    case (opc)
      0: begin
        e.b = rd2; e.wr = ins[15:11]; e.rw = 1;
        if      (fn == 32) e.alu = 0;
        else if (fn == 34) e.alu = 1;
        else if (fn == 36) e.alu = 2;
        else if (fn == 37) e.alu = 3;
        else if (fn == 42) e.alu = 4;
        else ok = 0;
      end
      8:  begin e.alu = 0; e.b = simm; e.rw = 1; e.wr = ins[20:16]; end
      12: begin e.alu = 2; e.b = {16'h0, ins[15:0]}; e.rw = 1; e.wr = ins[20:16]; end
      35: begin e.alu = 0; e.b = simm; e.mr = 1; e.rw = 1; e.wr = ins[20:16]; end
      43: begin e.alu = 0; e.b = simm; e.mw = 1; e.st = rd2; end
      4:  begin e.alu = 1; e.b = rd2; e.br = 1; end
      5:  begin e.alu = 1; e.b = rd2; e.br = 1; e.bne = 1; end
      2:  begin e.alu = 4'hF; e.a = 0; e.j = 1; end
      default: ok = 0;
    endcase
    if (!ok) begin
      e = bubble();
      e.ill = 1;
    end else begin
      e.v = 1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".ALUcontrol"}, 32'(ALUcontrol), 32'(m.alu));
    chk({ctx, ".OperandA"},   OperandA,        m.a);
    chk({ctx, ".OperandB"},   OperandB,        m.b);
    chk({ctx, ".StoreData"},  StoreData,       m.st);
    chk({ctx, ".WriteReg"},   32'(WriteReg),   32'(m.wr));
    chk({ctx, ".flags"},
        32'({RegWrite, MemRead, MemWrite, Branch, BranchNe, Jump, ExValid, Illegal}),
        32'({m.rw, m.mr, m.mw, m.br, m.bne, m.j, m.v, m.ill}));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input string ctx, input logic [31:0] ins, input logic [31:0] rd1,
                      input logic [31:0] rd2, input logic inv, input logic stl, input logic fl);
    exp_t d;
    Instruction = ins; ReadData1 = rd1; ReadData2 = rd2;
    InValid = inv; Stall = stl; Flush = fl;
    d = ref_decode(ins, rd1, rd2);
    if (fl)        m = bubble();
    else if (!stl) m = inv ? d : bubble();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  ops [9];
    logic [5:0]  fns [5];
    int          k;
    ops = '{6'h00, 6'h08, 6'h0C, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) r[31:26] = ops[k];
    if (r[31:26] == 6'h00 && $urandom_range(0, 5) != 0) r[5:0] = fns[$urandom_range(0, 4)];
    return r;
  endfunction

  initial begin
    reset = 1'b1; Instruction = 0; InValid = 0; Stall = 0; Flush = 0;
    ReadData1 = 0; ReadData2 = 0;
    m = bubble();
    #2;
    check_all("reset_async");
    @(posedge clk); @(posedge clk); #1;
    check_all("reset");
    reset = 1'b0;

    step("add", 32'h00221820, 5, 7, 1, 0, 0);
    chk("add.ALU", 32'(ALUcontrol), 0);
    chk("add.B", OperandB, 7);
    chk("add.WriteReg", 32'(WriteReg), 3);

    step("addi", 32'h2022FFFC, 10, 99, 1, 0, 0);
    chk("addi.B", OperandB, 32'hFFFFFFFC);
    chk("addi.A", OperandA, 10);

    step("andi", 32'h30228001, 10, 99, 1, 0, 0);
    chk("andi.B", OperandB, 32'h00008001);
    chk("andi.ALU", 32'(ALUcontrol), 2);

    step("sw", 32'hAC850008, 32'h100, 32'hAB, 1, 0, 0);
    chk("sw.B", OperandB, 8);
    chk("sw.StoreData", StoreData, 32'hAB);
    chk("sw.MemWrite_RegWrite", 32'({MemWrite, RegWrite}), 32'b10);

    step("bne", 32'h14220003, 3, 4, 1, 0, 0);
    chk("bne.ALU", 32'(ALUcontrol), 1);
    chk("bne.Branch", 32'({Branch, BranchNe}), 32'b11);

    step("j", 32'h08000040, 3, 4, 1, 0, 0);
    step("invalid", 32'h00221820, 5, 7, 0, 0, 0);

    step("lw", 32'h8C430010, 32'h200, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("lw_stall", rand_instr(), $urandom, $urandom, 1, 1, 0);
    chk("lw_stall.MemRead", 32'(MemRead), 1);
    chk("lw_stall.A", OperandA, 32'h200);
    step("stall_flush", 32'h00221820, 5, 7, 1, 1, 1);
    chk("stall_flush.ExValid_ALU", 32'({ExValid, ALUcontrol}), 32'h0F);

    step("illegal", 32'hFC000000, 1, 2, 1, 0, 0);
    chk("illegal.Illegal", 32'(Illegal), 1);
    step("illegal_stall", 32'h00221820, 1, 2, 1, 1, 0);
    step("after_illegal", 32'h00221820, 1, 2, 1, 0, 0);
    chk("after_illegal.Illegal", 32'(Illegal), 0);
    step("bad_funct", 32'h00221821, 1, 2, 1, 0, 0);
    step("flush", 32'h00221820, 1, 2, 1, 0, 1);

    // Async reset mid-cycle while a held instruction sits in EX.
    step("pre_reset", 32'h00221820, 5, 7, 1, 0, 0);
    step("pre_reset_stall", 32'h2022FFFC, 1, 1, 1, 1, 0);
    #2;
    reset = 1'b1;
    m = bubble();
    #1;
    check_all("reset_midcycle");
    @(posedge clk); @(posedge clk); #1;
    check_all("reset_hold");
    reset = 1'b0;
    step("post_reset_stall", 32'h00221820, 5, 7, 1, 1, 0);
    step("post_reset_add", 32'h00221820, 5, 7, 1, 0, 0);
    chk("post_reset_add.ExValid", 32'(ExValid), 1);

    for (int i = 0; i < 400; i++) begin
      step("rand", rand_instr(), $urandom, $urandom,
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
